// File: rtl/window_pkg.sv
// Shared definitions for the reserved-window coefficient path.
package window_pkg;

   localparam int WIN_DEPTH  = 256;
   localparam int WIN_ADDR_W = 8;
   localparam int WIN_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      DRAIN  = 2'd2,
      COMMIT = 2'd3
   } loader_state_t;

endpackage

// File: rtl/window_coef_loader.sv
// Writer side of the window coefficient RAM: streams one DEPTH-long table into the RAM
// and only selects it when the frame length was exactly right.
module window_coef_loader
   import window_pkg::*;
#(
   parameter int DEPTH  = WIN_DEPTH,
   parameter int ADDR_W = WIN_ADDR_W,
   parameter int DATA_W = WIN_DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_load,
   input  logic                cmd_use_rom,
   input  logic [DATA_W-1:0]   s_tdata,
   input  logic                s_tvalid,
   input  logic                s_tlast,
   output logic                s_tready,
   output logic                ram_wr_en,
   output logic [ADDR_W-1:0]   ram_wr_addr,
   output logic [DATA_W-1:0]   ram_wr_data,
   output logic                ram_sel_pulse,
   output logic                rom_sel_pulse,
   output logic                busy,
   output logic                done,
   output logic                err_len,
   output logic [ADDR_W:0]     word_cnt,
   output logic [DATA_W-1:0]   checksum,
   output loader_state_t       state_dbg
);

   // Stream handshake: a beat transfers on a rising clk edge where s_tvalid && s_tready;
   // s_tready depends only on state, so it never combinationally depends on s_tvalid.

   loader_state_t state, state_nxt;
   logic          accept;
   logic          last_slot;

   assign s_tready  = (state == LOAD) || (state == DRAIN);
   assign busy      = s_tready;
   assign accept    = s_tvalid && s_tready;
   assign last_slot = (word_cnt == (ADDR_W+1)'(DEPTH-1));
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cmd_load) state_nxt = LOAD;
         end
         LOAD: begin
            if (accept) begin
               if (s_tlast)        state_nxt = last_slot ? COMMIT : IDLE;
               else if (last_slot) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (accept && s_tlast) state_nxt = IDLE;
         end
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_wr_en     <= 1'b0;
         ram_wr_addr   <= '0;
         ram_wr_data   <= '0;
         ram_sel_pulse <= 1'b0;
         rom_sel_pulse <= 1'b0;
         done          <= 1'b0;
         err_len       <= 1'b0;
         word_cnt      <= '0;
         checksum      <= '0;
      end else begin
         ram_wr_en     <= 1'b0;
         ram_sel_pulse <= 1'b0;
         rom_sel_pulse <= 1'b0;
         case (state)
            IDLE: begin
               // Fall back to ROM before touching the RAM so a half-written table is never live.
               if (cmd_load) begin
                  done          <= 1'b0;
                  err_len       <= 1'b0;
                  word_cnt      <= '0;
                  checksum      <= '0;
                  rom_sel_pulse <= 1'b1;
               end else if (cmd_use_rom) begin
                  rom_sel_pulse <= 1'b1;
               end
            end
            LOAD: begin
               if (accept) begin
                  ram_wr_en   <= 1'b1;
                  ram_wr_addr <= word_cnt[ADDR_W-1:0];
                  ram_wr_data <= s_tdata;
                  word_cnt    <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
                  checksum    <= checksum ^ s_tdata;
                  if (s_tlast && !last_slot) err_len <= 1'b1;
               end
            end
            DRAIN: begin
               if (accept && s_tlast) err_len <= 1'b1;
            end
            COMMIT: begin
               ram_sel_pulse <= 1'b1;
               done          <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_window_coef_loader.sv
// Randomized scoreboard bench for window_coef_loader: frames of varied length and gaps
// against a frame-level model of writes, select pulses and final status.
module tb_window_coef_loader;
   import window_pkg::*;

   localparam int DEPTH  = WIN_DEPTH;
   localparam int ADDR_W = WIN_ADDR_W;
   localparam int DATA_W = WIN_DATA_W;

   logic                clk;
   logic                rst_n;
   logic                cmd_load;
   logic                cmd_use_rom;
   logic [DATA_W-1:0]   s_tdata;
   logic                s_tvalid;
   logic                s_tlast;
   logic                s_tready;
   logic                ram_wr_en;
   logic [ADDR_W-1:0]   ram_wr_addr;
   logic [DATA_W-1:0]   ram_wr_data;
   logic                ram_sel_pulse;
   logic                rom_sel_pulse;
   logic                busy;
   logic                done;
   logic                err_len;
   logic [ADDR_W:0]     word_cnt;
   logic [DATA_W-1:0]   checksum;
   loader_state_t       state_dbg;

   window_coef_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_load      (cmd_load),
      .cmd_use_rom   (cmd_use_rom),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tlast       (s_tlast),
      .s_tready      (s_tready),
      .ram_wr_en     (ram_wr_en),
      .ram_wr_addr   (ram_wr_addr),
      .ram_wr_data   (ram_wr_data),
      .ram_sel_pulse (ram_sel_pulse),
      .rom_sel_pulse (rom_sel_pulse),
      .busy          (busy),
      .done          (done),
      .err_len       (err_len),
      .word_cnt      (word_cnt),
      .checksum      (checksum),
      .state_dbg     (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];     // expected RAM writes {addr, data}
   logic                     exp_sel_q[$]; // expected select pulses: 1 = RAM, 0 = ROM

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sel_event(input logic kind);
      if (exp_sel_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_sel_pulse: got kind %0d expected none", kind);
      end else begin
         check("sel_pulse_kind", 72'(kind), 72'(exp_sel_q.pop_front()));
      end
   endtask

   always @(negedge clk) begin
      if (ram_wr_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                     ram_wr_addr, ram_wr_data);
         end else begin
            check("ram_write", {ram_wr_addr, ram_wr_data}, 72'(exp_q.pop_front()));
         end
      end
      if (rom_sel_pulse) sel_event(1'b0);
      if (ram_sel_pulse) sel_event(1'b1);
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      cmd_load    = 1'b0;
      cmd_use_rom = 1'b0;
      s_tvalid    = 1'b0;
      s_tlast     = 1'b0;
      s_tdata     = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_status(input string tag, input bit exp_done, input bit exp_err,
                               input int exp_cnt, input logic [DATA_W-1:0] exp_ck);
      check({tag, "_busy"},     72'(busy),     72'(0));
      check({tag, "_done"},     72'(done),     72'(exp_done));
      check({tag, "_err_len"},  72'(err_len),  72'(exp_err));
      check({tag, "_word_cnt"}, 72'(word_cnt), 72'(exp_cnt));
      check({tag, "_checksum"}, 72'(checksum), 72'(exp_ck));
      check({tag, "_wr_q_empty"},  72'(exp_q.size()),     72'(0));
      check({tag, "_sel_q_empty"}, 72'(exp_sel_q.size()), 72'(0));
   endtask

   // One load of len beats with tlast on the last one. Model: the first min(len, DEPTH)
   // beats land at addresses 0.. in order; only len == DEPTH commits the table.
   task automatic run_frame(input string tag, input int len, input bit ramp, input int gap_pct,
                            input bit both_cmds, input bit poke_cmds, input int abort_at);
      logic [DATA_W-1:0] beat;
      logic [DATA_W-1:0] exp_ck;
      int                guard;
      exp_ck = '0;
      @(negedge clk);
      cmd_load    = 1'b1;
      cmd_use_rom = both_cmds;
      exp_sel_q.push_back(1'b0);
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < len; i++) begin
         beat = ramp ? DATA_W'(i) : {$urandom, $urandom};
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_tvalid = 1'b0;
            @(negedge clk);
         end
         s_tvalid = 1'b1;
         s_tdata  = beat;
         s_tlast  = (i == len - 1);
         if (poke_cmds && i == 10) begin
            cmd_load    = 1'b1;
            cmd_use_rom = 1'b1;
         end
         guard = 0;
         while (!s_tready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard == 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_tready_timeout: got s_tready=0 expected 1 at beat %0d", tag, i);
            idle_inputs();
            return;
         end
         if (i < DEPTH) begin
            exp_q.push_back({ADDR_W'(i), beat});
            exp_ck ^= beat;
         end
         @(posedge clk);
         @(negedge clk);
         idle_inputs();
         if (abort_at == i + 1) begin
            #1 rst_n = 1'b0;
            #1;
            check({tag, "_abort_busy"},   72'(busy),          72'(0));
            check({tag, "_abort_tready"}, 72'(s_tready),      72'(0));
            check({tag, "_abort_ramsel"}, 72'(ram_sel_pulse), 72'(0));
            @(negedge clk);
            rst_n = 1'b1;
            wait_cycles(4);
            check_status(tag, 1'b0, 1'b0, 0, '0);
            return;
         end
      end
      if (len == DEPTH) exp_sel_q.push_back(1'b1);
      wait_cycles(4);
      check_status(tag, len == DEPTH, len != DEPTH, (len < DEPTH) ? len : DEPTH, exp_ck);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      idle_inputs();
      #23;
      check("reset_tready",   72'(s_tready),      72'(0));
      check("reset_wr_en",    72'(ram_wr_en),     72'(0));
      check("reset_wr_addr",  72'(ram_wr_addr),   72'(0));
      check("reset_wr_data",  72'(ram_wr_data),   72'(0));
      check("reset_ram_sel",  72'(ram_sel_pulse), 72'(0));
      check("reset_rom_sel",  72'(rom_sel_pulse), 72'(0));
      check_status("reset", 1'b0, 1'b0, 0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(3);
      check("post_reset_tready", 72'(s_tready), 72'(0));

      run_frame("good_ramp",  DEPTH, 1'b1, 0,  1'b0, 1'b0, 0);
      run_frame("short",      100,   1'b0, 0,  1'b0, 1'b0, 0);
      run_frame("long",       300,   1'b0, 0,  1'b0, 1'b0, 0);
      run_frame("gaps_ramp",  DEPTH, 1'b1, 40, 1'b0, 1'b0, 0);

      @(negedge clk);
      cmd_use_rom = 1'b1;
      exp_sel_q.push_back(1'b0);
      @(negedge clk);
      cmd_use_rom = 1'b0;
      wait_cycles(3);
      check("use_rom_sel_q_empty", 72'(exp_sel_q.size()), 72'(0));
      check("use_rom_busy",        72'(busy),             72'(0));

      run_frame("both_cmds_poke", DEPTH, 1'b0, 20, 1'b1, 1'b1, 0);
      run_frame("abort50",        120,   1'b0, 0,  1'b0, 1'b0, 50);
      run_frame("edge_255",       DEPTH - 1, 1'b0, 10, 1'b0, 1'b0, 0);
      run_frame("edge_257",       DEPTH + 1, 1'b0, 10, 1'b0, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         run_frame("random", (k == 1) ? DEPTH : $urandom_range(1, 320), 1'b0,
                   $urandom_range(0, 50), 1'b0, 1'b0, 0);
      end

      wait_cycles(3);
      check("final_wr_q_empty",  72'(exp_q.size()),     72'(0));
      check("final_sel_q_empty", 72'(exp_sel_q.size()), 72'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
